l2_request_select: RTL and testbench

//  Downstream consumer of the L2 round-robin arbiter. Presents per-port request-queue heads to the arbiter and takes its grant.

---
 rtl/l2_config_and_types.sv | 27 ++
 rtl/l2_arbitration_interface.sv | 30 +++
 rtl/l2_slot_reg.sv | 28 ++
 rtl/l2_request_select.sv | 130 +++++++++++++
 tb/tb_l2_request_select.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_config_and_types.sv
// rtl/l2_config_and_types.sv - shared L2 configuration constants and types
package l2_config_and_types;

    localparam int L2_NUM_PORTS = 4;
    localparam int L2_ADDR_W    = 30;
    localparam int L2_DATA_W    = 32;
    localparam int L2_BURST_W   = 5;

    // A single port still needs a 1-bit id field; its value is always 0.
    function automatic int l2_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int L2_ID_W = l2_id_width(L2_NUM_PORTS);

    typedef struct packed {
        logic [L2_ADDR_W-1:0]  addr;
        logic                  rnw;
        logic [L2_BURST_W-1:0] len;
    } l2_req_fields_t;

    typedef enum logic [0:0] {
        L2_SEL_IDLE = 1'b0,
        L2_SEL_DATA = 1'b1
    } l2_sel_state_t;

endpackage

// File: rtl/l2_arbitration_interface.sv
// rtl/l2_arbitration_interface.sv - request/grant/strobe link to the L2 round-robin arbiter
interface l2_arbitration_interface
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS
);
    localparam int ID_W = l2_id_width(NUM_PORTS);

    logic [NUM_PORTS-1:0] requests;
    logic                 strobe;
    logic [ID_W-1:0]      grantee_i;
    logic [NUM_PORTS-1:0] grantee_v;
    logic                 grantee_valid;

    modport master (
        output requests,
        output strobe,
        input  grantee_i,
        input  grantee_v,
        input  grantee_valid
    );

    modport slave (
        input  requests,
        input  strobe,
        output grantee_i,
        output grantee_v,
        output grantee_valid
    );
endinterface

// File: rtl/l2_slot_reg.sv
// rtl/l2_slot_reg.sv - single-entry valid/ready pipeline register
module l2_slot_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    // Ready while empty or being drained this cycle, so back-to-back loads see no bubble.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/l2_request_select.sv
// rtl/l2_request_select.sv - pops arbiter-granted L2 requests into an output slot and forwards write bursts
module l2_request_select
    import l2_config_and_types::*;
#(
    parameter int   NUM_PORTS = L2_NUM_PORTS,
    parameter int   ADDR_W    = L2_ADDR_W,
    parameter int   DATA_W    = L2_DATA_W,
    parameter int   BURST_W   = L2_BURST_W,
    localparam int  ID_W      = l2_id_width(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0]              req_rnw,
    input  logic [NUM_PORTS-1:0][BURST_W-1:0] req_len,
    output logic [NUM_PORTS-1:0]              req_pop,
    input  logic [NUM_PORTS-1:0]              wd_valid,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wd_data,
    output logic [NUM_PORTS-1:0]              wd_pop,
    l2_arbitration_interface.master           arb,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_W-1:0]                 out_addr,
    output logic                              out_rnw,
    output logic [BURST_W-1:0]                out_len,
    output logic [ID_W-1:0]                   out_id,
    output logic                              out_wd_valid,
    input  logic                              out_wd_ready,
    output logic [DATA_W-1:0]                 out_wd_data,
    output logic                              out_wd_last
);
    localparam int REQ_W = ADDR_W + 1 + BURST_W + ID_W;
    localparam int WD_W  = DATA_W + 1;

    l2_sel_state_t      state_q, state_d;
    logic [ID_W-1:0]    lock_q, lock_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               wd_accept;
    logic               req_slot_ready;
    logic               wd_slot_ready;
    logic [REQ_W-1:0]   req_slot_in;
    logic [REQ_W-1:0]   req_slot_out;
    logic [WD_W-1:0]    wd_slot_in;
    logic [WD_W-1:0]    wd_slot_out;

    assign grant_id     = (NUM_PORTS == 1) ? '0 : arb.grantee_i;
    assign arb.requests = (state_q == L2_SEL_IDLE) ? req_valid : '0;

    // Reset gates the handshakes so nothing is dequeued while the block is held.
    assign accept    = ~rst && (state_q == L2_SEL_IDLE) && arb.grantee_valid && req_slot_ready;
    assign wd_accept = ~rst && (state_q == L2_SEL_DATA) && wd_valid[lock_q] && wd_slot_ready;

    assign arb.strobe = accept;
    assign req_pop    = accept ? arb.grantee_v : '0;

    always_comb begin
        wd_pop = '0;
        if (wd_accept) begin
            wd_pop[lock_q] = 1'b1;
        end
    end

    assign req_slot_in = {req_addr[grant_id], req_rnw[grant_id], req_len[grant_id], grant_id};
    assign wd_slot_in  = {wd_data[lock_q], (count_q == '0)};

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        count_d = count_q;
        unique case (state_q)
            L2_SEL_IDLE: begin
                if (accept && !req_rnw[grant_id]) begin
                    state_d = L2_SEL_DATA;
                    lock_d  = grant_id;
                    count_d = req_len[grant_id];
                end
            end
            L2_SEL_DATA: begin
                if (wd_accept) begin
                    if (count_q == '0) begin
                        state_d = L2_SEL_IDLE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: state_d = L2_SEL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= L2_SEL_IDLE;
            lock_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            count_q <= count_d;
        end
    end

    l2_slot_reg #(.WIDTH(REQ_W)) u_req_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_ready  (req_slot_ready),
        .in_data   (req_slot_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (req_slot_out)
    );

    l2_slot_reg #(.WIDTH(WD_W)) u_wd_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wd_accept),
        .in_ready  (wd_slot_ready),
        .in_data   (wd_slot_in),
        .out_valid (out_wd_valid),
        .out_ready (out_wd_ready),
        .out_data  (wd_slot_out)
    );

    assign {out_addr, out_rnw, out_len, out_id} = req_slot_out;
    assign {out_wd_data, out_wd_last}           = wd_slot_out;
endmodule

// File: tb/tb_l2_request_select.sv
// tb/tb_l2_request_select.sv - directed vector bench for l2_request_select
module tb_l2_request_select;
    import l2_config_and_types::*;

    localparam int NP = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BW = 5;
    localparam int IW = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NP-1:0]            req_valid;
    logic [NP-1:0][AW-1:0]    req_addr;
    logic [NP-1:0]            req_rnw;
    logic [NP-1:0][BW-1:0]    req_len;
    logic [NP-1:0]            req_pop;
    logic [NP-1:0]            wd_valid;
    logic [NP-1:0][DW-1:0]    wd_data;
    logic [NP-1:0]            wd_pop;
    logic                     out_valid;
    logic                     out_ready;
    logic [AW-1:0]            out_addr;
    logic                     out_rnw;
    logic [BW-1:0]            out_len;
    logic [IW-1:0]            out_id;
    logic                     out_wd_valid;
    logic                     out_wd_ready;
    logic [DW-1:0]            out_wd_data;
    logic                     out_wd_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_arbitration_interface #(.NUM_PORTS(NP)) arb_if ();

    l2_request_select #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_rnw      (req_rnw),
        .req_len      (req_len),
        .req_pop      (req_pop),
        .wd_valid     (wd_valid),
        .wd_data      (wd_data),
        .wd_pop       (wd_pop),
        .arb          (arb_if),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_rnw      (out_rnw),
        .out_len      (out_len),
        .out_id       (out_id),
        .out_wd_valid (out_wd_valid),
        .out_wd_ready (out_wd_ready),
        .out_wd_data  (out_wd_data),
        .out_wd_last  (out_wd_last)
    );

    // Stand-in round-robin arbiter: first requester after the last strobed grantee.
    logic [IW-1:0] rr_last;
    always_comb begin
        int  idx;
        logic found;
        found                = 1'b0;
        arb_if.grantee_valid = 1'b0;
        arb_if.grantee_i     = '0;
        arb_if.grantee_v     = '0;
        for (int k = 1; k <= NP; k++) begin
            idx = (int'(rr_last) + k) % NP;
            if (!found && arb_if.requests[idx]) begin
                found                = 1'b1;
                arb_if.grantee_valid = 1'b1;
                arb_if.grantee_i     = IW'(idx);
                arb_if.grantee_v[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_last <= IW'(NP - 1);
        else if (arb_if.strobe) rr_last <= arb_if.grantee_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NP-1:0] rv;
        logic          ordy;
        logic [NP-1:0] pop;
        logic          ev;
        logic [IW-1:0] id;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[4]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};
        vecs[5]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[9]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        rst          = 1'b1;
        req_valid    = '1;
        req_rnw      = '1;
        out_ready    = 1'b0;
        out_wd_ready = 1'b0;
        wd_valid     = '0;
        for (int i = 0; i < NP; i++) begin
            req_addr[i] = AW'(32'h100 + i);
            req_len[i]  = '0;
            wd_data[i]  = 32'hA000_0000 + i;
        end

        // Reset held with every port requesting
        for (int c = 0; c < 3; c++) begin
            to_edge();
            @(negedge clk);
            check("rst_strobe", arb_if.strobe, 1'b0);
            check("rst_req_pop", req_pop, 4'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_wd_valid", out_wd_valid, 1'b0);
        end
        to_edge();
        rst = 1'b0;

        // Back-to-back reads, then slot backpressure
        for (int v = 0; v < 11; v++) begin
            req_valid = vecs[v].rv;
            out_ready = vecs[v].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_req_pop", v), req_pop, vecs[v].pop);
            check($sformatf("vec%0d_strobe", v), arb_if.strobe, |vecs[v].pop);
            to_edge();
            check($sformatf("vec%0d_out_valid", v), out_valid, vecs[v].ev);
            if (vecs[v].ev) begin
                check($sformatf("vec%0d_out_id", v), out_id, vecs[v].id);
                check($sformatf("vec%0d_out_addr", v), out_addr, 32'h100 + vecs[v].id);
                check($sformatf("vec%0d_out_rnw", v), out_rnw, 1'b1);
            end
        end

        // Port 2 write len=3 with port 1 read waiting
        req_len[2]   = 5'd3;
        req_rnw      = 4'b1011;
        req_valid    = 4'b0100;
        out_ready    = 1'b1;
        out_wd_ready = 1'b1;
        wd_valid     = 4'b1111;
        @(negedge clk);
        check("wr_grant_pop", req_pop, 4'b0100);
        to_edge();
        check("wr_out_rnw", out_rnw, 1'b0);
        check("wr_out_len", out_len, 5'd3);
        check("wr_out_id", out_id, 2'd2);
        req_valid = 4'b0010;
        for (int w = 0; w < 4; w++) begin
            wd_data[2] = 32'hD200_0000 + w;
            @(negedge clk);
            check("burst_wd_pop", wd_pop, 4'b0100);
            check("burst_req_pop", req_pop, 4'b0);
            check("burst_requests", arb_if.requests, 4'b0);
            to_edge();
            check("burst_wd_valid", out_wd_valid, 1'b1);
            check("burst_wd_data", out_wd_data, 32'hD200_0000 + w);
            check("burst_wd_last", out_wd_last, w == 3);
        end
        wd_valid[2] = 1'b0;
        @(negedge clk);
        check("after_burst_req_pop", req_pop, 4'b0010);
        check("after_burst_wd_pop", wd_pop, 4'b0);
        to_edge();
        check("after_burst_out_id", out_id, 2'd1);
        check("after_burst_wd_valid", out_wd_valid, 1'b0);
        req_valid = '0;
        wd_valid  = '0;

        // Port 3 write len=0, data late, then output stalled
        req_len[3] = 5'd0;
        req_rnw    = 4'b0111;
        req_valid  = 4'b1000;
        @(negedge clk);
        check("w0_grant_pop", req_pop, 4'b1000);
        to_edge();
        check("w0_out_id", out_id, 2'd3);
        req_valid    = 4'b0001;
        out_wd_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("w0_wait_requests", arb_if.requests, 4'b0);
            check("w0_wait_req_pop", req_pop, 4'b0);
            check("w0_wait_wd_pop", wd_pop, 4'b0);
            to_edge();
        end
        wd_valid[3] = 1'b1;
        wd_data[3]  = 32'h3333_0001;
        @(negedge clk);
        check("w0_wd_pop", wd_pop, 4'b1000);
        to_edge();
        wd_data[3] = 32'h3333_0002;
        @(negedge clk);
        check("w0_next_grant", req_pop, 4'b0001);
        to_edge();
        req_valid = '0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("w0_hold_wd_pop", wd_pop, 4'b0);
            to_edge();
            check("w0_hold_valid", out_wd_valid, 1'b1);
            check("w0_hold_data", out_wd_data, 32'h3333_0001);
            check("w0_hold_last", out_wd_last, 1'b1);
        end
        out_wd_ready = 1'b1;
        wd_valid     = '0;
        to_edge();
        check("w0_drained", out_wd_valid, 1'b0);

        // Reset in the middle of a len=7 burst from port 1
        req_len[1] = 5'd7;
        req_rnw    = 4'b1101;
        req_valid  = 4'b0010;
        out_ready  = 1'b0;
        @(negedge clk);
        check("w7_grant_pop", req_pop, 4'b0010);
        to_edge();
        req_valid   = '0;
        wd_valid[1] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            wd_data[1] = 32'h1111_0000 + w;
            @(negedge clk);
            check("w7_wd_pop", wd_pop, 4'b0010);
            to_edge();
            check("w7_wd_data", out_wd_data, 32'h1111_0000 + w);
        end
        check("w7_out_valid_pre_rst", out_valid, 1'b1);
        rst       = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("w7_rst_wd_pop", wd_pop, 4'b0);
        check("w7_rst_strobe", arb_if.strobe, 1'b0);
        to_edge();
        check("w7_rst_out_valid", out_valid, 1'b0);
        check("w7_rst_wd_valid", out_wd_valid, 1'b0);
        check("w7_rst_wd_last", out_wd_last, 1'b0);
        check("w7_rst_requests", arb_if.requests, 4'b0100);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("w7_resume_pop", req_pop, 4'b0100);
        check("w7_resume_wd_pop", wd_pop, 4'b0);
        to_edge();
        check("w7_resume_out_valid", out_valid, 1'b1);
        check("w7_resume_out_id", out_id, 2'd2);
        req_valid = '0;
        wd_valid  = '0;
        to_edge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
